wb_regfile_unit: RTL and testbench
==================================

Name: wb_regfile_unit

Overview:
- Consumer end of the M/WB pipeline register; the writeback stage.
- Selects the writeback value, commits it to the 4x8 architectural register file (R0-R3), and serves two decode-stage read ports with same-cycle write-through.
- OUT-instruction values are queued in a small output FIFO drained by a valid/ready port interface.

Parameters:
- SP_RESET, 8'hFF, reset value of R3 (stack pointer); R0-R2 reset to 8'h00.
- OUT_DEPTH, 4, output FIFO depth in entries; power of two, >= 2.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  reset, synchronous, active-high.
- wb_alu_res  input  8  ALU result from M/WB register.
- wb_mem_data  input  8  memory read data from M/WB register.
- wb_dist  input  2  destination register index.
- wb_mem_to_reg  input  1  1 = write back memory data, 0 = ALU result.
- wb_reg_write  input  1  register-file write enable.
- wb_output_valid  input  1  OUT instruction in WB; push writeback value to FIFO.
- rd_addr_a  input  2  read port A index.
- rd_addr_b  input  2  read port B index.
- out_ready  input  1  external sink accepts out_data this cycle.
- rd_data_a  output  8  read port A data (combinational).
- rd_data_b  output  8  read port B data (combinational).
- out_data  output  8  FIFO head value.
- out_valid  output  1  FIFO non-empty.
- out_full  output  1  FIFO holds OUT_DEPTH entries; decode stalls OUT issue on this.
- out_overflow  output  1  sticky; a push was dropped.

Behaviour:
- wb_value = wb_mem_to_reg ? wb_mem_data : wb_alu_res. Combinational, no latency.
- Register write:
  - On posedge with wb_reg_write=1 and rst=0: R[wb_dist] <= wb_value.
  - R3 is writable like the others.
- Reads:
  - rd_data_x = (wb_reg_write && wb_dist==rd_addr_x) ? wb_value : R[rd_addr_x].
  - Bypass applies to both ports independently.
  - Zero-cycle RAW: a value written this cycle is visible to decode in the same cycle.
- FIFO:
  - Circular buffer; wr_ptr, rd_ptr each log2(OUT_DEPTH) bits, wrapping modulo OUT_DEPTH.
  - count is 0..OUT_DEPTH, log2(OUT_DEPTH)+1 bits.
  - out_valid = (count != 0).
  - out_data = mem[rd_ptr]; holds a stable value while out_valid=1 and out_ready=0.
  - out_full = (count == OUT_DEPTH).
- Pop: pop = out_valid && out_ready. On pop, rd_ptr increments.
- Push: push = wb_output_valid && (!out_full || pop).
  - A push while full is accepted if a pop occurs in the same cycle.
  - On push, mem[wr_ptr] <= wb_value and wr_ptr increments.
- count update:
  - +1 on push only; -1 on pop only.
  - Unchanged when both or neither occur.
  - Simultaneous push+pop on an empty FIFO cannot occur, since pop needs out_valid.
- Overflow: wb_output_valid && out_full && !pop drops the value, and out_overflow <= 1.
  - The flag is cleared only by rst.
- A single WB entry with both wb_reg_write and wb_output_valid set performs both actions with the same wb_value.
- Reset (synchronous, any cycle, including mid-drain):
  - R0-R2 = 0, R3 = SP_RESET.
  - wr_ptr = rd_ptr = count = 0; out_overflow = 0.
  - Resulting outputs: out_valid = 0, out_full = 0.
  - FIFO storage contents are don't-care.
  - Writes and pushes presented in a reset cycle are ignored.
  - rd_data bypass still follows the combinational rule during reset.
- Latency:
  - Register write visible through the array one cycle after the WB cycle (bypass covers the WB cycle itself).
  - A pushed value appears at out_data the next cycle when the FIFO was empty.

Test Plan:
- Reset, then read all addresses -> R0-R2 = 8'h00, R3 = 8'hFF; out_valid=0, out_full=0, out_overflow=0.
- wb_reg_write=1, wb_dist=2, wb_mem_to_reg=1, wb_mem_data=8'h5A, wb_alu_res=8'h11, rd_addr_a=2 in the same cycle -> rd_data_a=8'h5A that cycle; after write is deasserted, rd_data_a=8'h5A from the array.
- Push 8'h01, 8'h02, 8'h03, 8'h04 with out_ready=0 -> out_full=1, out_data=8'h01. Fifth push 8'h05 with out_ready=0 -> dropped, out_overflow=1, count stays 4.
- From full, push 8'h06 with out_ready=1 in the same cycle -> 8'h01 popped, 8'h06 accepted, out_full stays 1, no overflow. Drain -> sequence 02, 03, 04, 06.
- Run 10 push/pop pairs through a depth-4 FIFO with out_ready toggling -> data order preserved across pointer wrap; count never exceeds 4.
- Assert rst while 3 entries are queued and R1=8'h33 -> next cycle out_valid=0, R1=8'h00, out_overflow=0; the push presented during the reset cycle is absent.

Source files
------------

// File: rtl/wb_regfile_unit.sv
// Writeback stage: selects the writeback value, commits it to the 4x8 register
// file with same-cycle read bypass, and queues OUT values in a small FIFO
// drained over a valid/ready port.
module wb_regfile_unit #(
  parameter logic [7:0]  SP_RESET  = 8'hFF,
  parameter int unsigned OUT_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] wb_alu_res,
  input  logic [7:0] wb_mem_data,
  input  logic [1:0] wb_dist,
  input  logic       wb_mem_to_reg,
  input  logic       wb_reg_write,
  input  logic       wb_output_valid,
  input  logic [1:0] rd_addr_a,
  input  logic [1:0] rd_addr_b,
  input  logic       out_ready,
  output logic [7:0] rd_data_a,
  output logic [7:0] rd_data_b,
  output logic [7:0] out_data,
  output logic       out_valid,
  output logic       out_full,
  output logic       out_overflow
);

  localparam int unsigned DATA_W = 8;
  localparam int unsigned PTR_W  = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
  localparam int unsigned CNT_W  = PTR_W + 1;

  logic [DATA_W-1:0] r_regs [4];
  logic [DATA_W-1:0] r_mem  [OUT_DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic              r_overflow;

  logic [DATA_W-1:0] w_wb_value;
  logic              w_full;
  logic              w_valid;
  logic              w_pop;
  logic              w_push;
  logic              w_drop;

  // Writeback value mux: memory load data or ALU result.
  always_comb begin
    w_wb_value = wb_mem_to_reg ? wb_mem_data : wb_alu_res;
  end

  // Decode read ports with write-through so a same-cycle RAW sees the new value.
  always_comb begin
    rd_data_a = r_regs[rd_addr_a];
    rd_data_b = r_regs[rd_addr_b];
    if (wb_reg_write && (wb_dist == rd_addr_a)) rd_data_a = w_wb_value;
    if (wb_reg_write && (wb_dist == rd_addr_b)) rd_data_b = w_wb_value;
  end

  // Architectural register file; R3 doubles as the stack pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_regs[0] <= '0;
      r_regs[1] <= '0;
      r_regs[2] <= '0;
      r_regs[3] <= SP_RESET;
    end else if (wb_reg_write) begin
      r_regs[wb_dist] <= w_wb_value;
    end
  end

  // FIFO handshake: a push into a full queue is allowed when the head leaves this cycle.
  always_comb begin
    w_full  = (r_count == CNT_W'(OUT_DEPTH));
    w_valid = (r_count != '0);
    w_pop   = w_valid && out_ready;
    w_push  = wb_output_valid && (!w_full || w_pop);
    w_drop  = wb_output_valid && w_full && !w_pop;
  end

  // FIFO storage; contents need no reset because count gates visibility.
  always_ff @(posedge clk) begin
    if (!rst && w_push) begin
      r_mem[r_wr_ptr] <= w_wb_value;
    end
  end

  // FIFO pointers, occupancy and sticky overflow flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
      if (w_drop) r_overflow <= 1'b1;
    end
  end

  // Port outputs derived from FIFO state.
  always_comb begin
    out_data     = r_mem[r_rd_ptr];
    out_valid    = w_valid;
    out_full     = w_full;
    out_overflow = r_overflow;
  end

endmodule

// File: tb/tb_wb_regfile_unit.sv
// Directed self-checking bench for the writeback stage.
module tb_wb_regfile_unit;

  logic       clk;
  logic       rst;
  logic [7:0] wb_alu_res;
  logic [7:0] wb_mem_data;
  logic [1:0] wb_dist;
  logic       wb_mem_to_reg;
  logic       wb_reg_write;
  logic       wb_output_valid;
  logic [1:0] rd_addr_a;
  logic [1:0] rd_addr_b;
  logic       out_ready;
  logic [7:0] rd_data_a;
  logic [7:0] rd_data_b;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_full;
  logic       out_overflow;

  int tests_run;
  int tests_failed;

  wb_regfile_unit #(.SP_RESET(8'hFF), .OUT_DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .wb_alu_res(wb_alu_res), .wb_mem_data(wb_mem_data), .wb_dist(wb_dist),
    .wb_mem_to_reg(wb_mem_to_reg), .wb_reg_write(wb_reg_write),
    .wb_output_valid(wb_output_valid),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .out_ready(out_ready),
    .rd_data_a(rd_data_a), .rd_data_b(rd_data_b), .out_data(out_data),
    .out_valid(out_valid), .out_full(out_full), .out_overflow(out_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; inputs are changed and outputs sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wb_alu_res = 8'h00; wb_mem_data = 8'h00; wb_dist = 2'd0;
    wb_mem_to_reg = 1'b0; wb_reg_write = 1'b0; wb_output_valid = 1'b0;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    logic [7:0] exp_r [4];
    exp_r[0] = 8'h00; exp_r[1] = 8'h00; exp_r[2] = 8'h00; exp_r[3] = 8'hFF;
    rst = 1'b1; idle(); rd_addr_a = 2'd0; rd_addr_b = 2'd0;
    tick(); tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rd_addr_a = 2'(i); rd_addr_b = 2'(3 - i);
      #1;
      tests_run++;
      if (rd_data_a !== exp_r[i]) begin
        tests_failed++; $display("FAIL reset_rd_a[%0d] got %h exp %h", i, rd_data_a, exp_r[i]);
      end
      tests_run++;
      if (rd_data_b !== exp_r[3 - i]) begin
        tests_failed++; $display("FAIL reset_rd_b[%0d] got %h exp %h", 3 - i, rd_data_b, exp_r[3 - i]);
      end
    end
    tests_run++;
    if ({out_valid, out_full, out_overflow} !== 3'b000) begin
      tests_failed++; $display("FAIL reset_fifo_flags got %b exp 000", {out_valid, out_full, out_overflow});
    end
  endtask

  task automatic test_bypass();
    // Memory data selected, same-cycle bypass on port A, port B untouched.
    wb_reg_write = 1'b1; wb_dist = 2'd2; wb_mem_to_reg = 1'b1;
    wb_mem_data = 8'h5A; wb_alu_res = 8'h11; rd_addr_a = 2'd2; rd_addr_b = 2'd1;
    #1;
    tests_run++;
    if (rd_data_a !== 8'h5A) begin
      tests_failed++; $display("FAIL bypass_a got %h exp 5a", rd_data_a);
    end
    tests_run++;
    if (rd_data_b !== 8'h00) begin
      tests_failed++; $display("FAIL bypass_b_other got %h exp 00", rd_data_b);
    end
    tick();
    idle();
    #1;
    tests_run++;
    if (rd_data_a !== 8'h5A) begin
      tests_failed++; $display("FAIL array_r2 got %h exp 5a", rd_data_a);
    end
    // ALU result selected, both ports bypass to R3.
    wb_reg_write = 1'b1; wb_dist = 2'd3; wb_mem_to_reg = 1'b0;
    wb_alu_res = 8'hC3; wb_mem_data = 8'h99; rd_addr_a = 2'd3; rd_addr_b = 2'd3;
    #1;
    tests_run++;
    if ({rd_data_a, rd_data_b} !== 16'hC3C3) begin
      tests_failed++; $display("FAIL bypass_both got %h exp c3c3", {rd_data_a, rd_data_b});
    end
    tick();
    idle();
    #1;
    tests_run++;
    if (rd_data_b !== 8'hC3) begin
      tests_failed++; $display("FAIL array_r3 got %h exp c3", rd_data_b);
    end
    // No bypass without write enable.
    wb_dist = 2'd0; wb_alu_res = 8'h77; rd_addr_a = 2'd0;
    #1;
    tests_run++;
    if (rd_data_a !== 8'h00) begin
      tests_failed++; $display("FAIL no_bypass_r0 got %h exp 00", rd_data_a);
    end
    tick();
    #1;
    tests_run++;
    if (rd_data_a !== 8'h00) begin
      tests_failed++; $display("FAIL no_write_r0 got %h exp 00", rd_data_a);
    end
    idle();
  endtask

  task automatic test_fifo_full();
    for (int i = 1; i <= 4; i++) begin
      wb_output_valid = 1'b1; wb_alu_res = 8'(i);
      tick();
      tests_run++;
      if (out_valid !== 1'b1 || out_data !== 8'h01) begin
        tests_failed++; $display("FAIL fill_head[%0d] got v=%b d=%h exp v=1 d=01", i, out_valid, out_data);
      end
      tests_run++;
      if (out_full !== (i == 4)) begin
        tests_failed++; $display("FAIL fill_full[%0d] got %b exp %b", i, out_full, (i == 4));
      end
    end
    tests_run++;
    if (out_overflow !== 1'b0) begin
      tests_failed++; $display("FAIL fill_no_overflow got %b exp 0", out_overflow);
    end
    wb_alu_res = 8'h05;
    tick();
    wb_output_valid = 1'b0;
    tests_run++;
    if ({out_overflow, out_full, out_data} !== {1'b1, 1'b1, 8'h01}) begin
      tests_failed++; $display("FAIL overflow_drop got ov=%b full=%b d=%h exp ov=1 full=1 d=01",
                                out_overflow, out_full, out_data);
    end
  endtask

  task automatic test_push_pop_full();
    logic [7:0] exp_d [4];
    exp_d[0] = 8'h02; exp_d[1] = 8'h03; exp_d[2] = 8'h04; exp_d[3] = 8'h06;
    wb_output_valid = 1'b1; wb_alu_res = 8'h06; out_ready = 1'b1;
    tick();
    wb_output_valid = 1'b0;
    tests_run++;
    if ({out_full, out_data} !== {1'b1, 8'h02}) begin
      tests_failed++; $display("FAIL push_pop_full got full=%b d=%h exp full=1 d=02", out_full, out_data);
    end
    for (int i = 0; i < 4; i++) begin
      tests_run++;
      if (out_valid !== 1'b1 || out_data !== exp_d[i]) begin
        tests_failed++; $display("FAIL drain[%0d] got v=%b d=%h exp v=1 d=%h", i, out_valid, out_data, exp_d[i]);
      end
      tick();
    end
    tests_run++;
    if ({out_valid, out_full, out_overflow} !== 3'b001) begin
      tests_failed++; $display("FAIL drain_empty got %b exp 001", {out_valid, out_full, out_overflow});
    end
    idle();
  endtask

  task automatic test_wrap();
    logic [7:0] q [$];
    int pushed;
    int popped;
    logic do_pop;
    logic do_push;
    logic [7:0] val;
    pushed = 0; popped = 0;
    for (int c = 0; c < 80 && popped < 10; c++) begin
      out_ready = ((c % 2) == 1);
      do_pop  = (q.size() != 0) && out_ready;
      do_push = (pushed < 10) && ((q.size() < 4) || do_pop);
      val = 8'hA0 + 8'(pushed);
      wb_output_valid = do_push; wb_alu_res = val;
      #1;
      tests_run++;
      if (out_valid !== (q.size() != 0) || out_full !== (q.size() == 4)) begin
        tests_failed++; $display("FAIL wrap_flags[%0d] got v=%b f=%b exp v=%b f=%b",
                                  c, out_valid, out_full, (q.size() != 0), (q.size() == 4));
      end
      if (q.size() != 0) begin
        tests_run++;
        if (out_data !== q[0]) begin
          tests_failed++; $display("FAIL wrap_data[%0d] got %h exp %h", c, out_data, q[0]);
        end
      end
      tick();
      if (do_pop) begin void'(q.pop_front()); popped++; end
      if (do_push) begin q.push_back(val); pushed++; end
    end
    idle();
    tests_run++;
    if (popped != 10) begin
      tests_failed++; $display("FAIL wrap_timeout popped %0d exp 10", popped);
    end
    tests_run++;
    if (out_valid !== 1'b0) begin
      tests_failed++; $display("FAIL wrap_empty got %b exp 0", out_valid);
    end
  endtask

  task automatic test_write_and_push();
    wb_reg_write = 1'b1; wb_output_valid = 1'b1; wb_dist = 2'd0;
    wb_mem_to_reg = 1'b1; wb_mem_data = 8'hE7; wb_alu_res = 8'h3C;
    tick();
    idle();
    rd_addr_a = 2'd0;
    #1;
    tests_run++;
    if ({rd_data_a, out_data, out_valid} !== {8'hE7, 8'hE7, 1'b1}) begin
      tests_failed++; $display("FAIL write_and_push got r0=%h d=%h v=%b exp r0=e7 d=e7 v=1",
                                rd_data_a, out_data, out_valid);
    end
    out_ready = 1'b1;
    tick();
    idle();
  endtask

  task automatic test_reset_mid();
    wb_reg_write = 1'b1; wb_dist = 2'd1; wb_alu_res = 8'h33;
    tick();
    idle();
    for (int i = 0; i < 3; i++) begin
      wb_output_valid = 1'b1; wb_alu_res = 8'h40 + 8'(i);
      tick();
    end
    idle();
    rd_addr_a = 2'd1;
    #1;
    tests_run++;
    if ({rd_data_a, out_valid} !== {8'h33, 1'b1}) begin
      tests_failed++; $display("FAIL pre_reset got r1=%h v=%b exp r1=33 v=1", rd_data_a, out_valid);
    end
    // Reset cycle with a write and a push presented; bypass still visible.
    rst = 1'b1; out_ready = 1'b1;
    wb_reg_write = 1'b1; wb_output_valid = 1'b1; wb_dist = 2'd0; wb_alu_res = 8'h99;
    rd_addr_a = 2'd0;
    #1;
    tests_run++;
    if (rd_data_a !== 8'h99) begin
      tests_failed++; $display("FAIL reset_bypass got %h exp 99", rd_data_a);
    end
    tick();
    rst = 1'b0;
    idle();
    rd_addr_a = 2'd1; rd_addr_b = 2'd0;
    #1;
    tests_run++;
    if ({out_valid, out_full, out_overflow} !== 3'b000) begin
      tests_failed++; $display("FAIL mid_reset_flags got %b exp 000", {out_valid, out_full, out_overflow});
    end
    tests_run++;
    if ({rd_data_a, rd_data_b} !== 16'h0000) begin
      tests_failed++; $display("FAIL mid_reset_regs got r1=%h r0=%h exp 00 00", rd_data_a, rd_data_b);
    end
    rd_addr_a = 2'd3;
    #1;
    tests_run++;
    if (rd_data_a !== 8'hFF) begin
      tests_failed++; $display("FAIL mid_reset_sp got %h exp ff", rd_data_a);
    end
    // A fresh push becomes head and a single pop empties the FIFO.
    wb_output_valid = 1'b1; wb_alu_res = 8'hAB;
    tick();
    idle();
    tests_run++;
    if ({out_valid, out_data} !== {1'b1, 8'hAB}) begin
      tests_failed++; $display("FAIL post_reset_push got v=%b d=%h exp v=1 d=ab", out_valid, out_data);
    end
    out_ready = 1'b1;
    tick();
    idle();
    tests_run++;
    if (out_valid !== 1'b0) begin
      tests_failed++; $display("FAIL post_reset_pop got %b exp 0", out_valid);
    end
  endtask

  initial begin
    tests_run = 0; tests_failed = 0;
    rst = 1'b1; idle(); rd_addr_a = 2'd0; rd_addr_b = 2'd0;
    test_reset();
    test_bypass();
    test_fifo_full();
    test_push_pop_full();
    test_wrap();
    test_write_and_push();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
